// File: rtl/fpu_compare_pipe.sv
// -----------------------------------------------------------------------------
// fpu_compare_pipe
//
// Purpose
//   Pipelined floating-point compare / min / max unit for FEQ, FLT, FLE, FMIN
//   and FMAX in single (S) and double (D) format. It accepts one op per cycle,
//   carries the destination register down a LATENCY-deep pipe and parks the
//   results in a small FIFO so writeback can apply back-pressure. Admission is
//   credit based (pipe occupancy + FIFO occupancy), so the pipe never stalls.
//
// Configuration macro
//   FPU_CMP_FLUSH_EN : adds the i_flush input. Flush discards everything in the
//                      pipe and FIFO at the clock edge and blocks acceptance
//                      during that cycle.
//
// Ports
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_flush         (FPU_CMP_FLUSH_EN only) discard all in-flight/buffered ops
//   i_valid/o_ready op handshake on the input side
//   i_op_is_double  1 = D format, 0 = S format (S operands NaN-boxed in low 32)
//   i_operand_a/b   operands
//   i_operation     riscv_pkg::instr_op_e opcode
//   i_dest_reg      destination register carried with the op
//   o_valid/i_ready result handshake (FIFO head, popped on o_valid & i_ready)
//   o_result        compare: 0/1 zero-extended; min/max: value (S NaN-boxed)
//   o_is_compare    1 = integer-destination compare result
//   o_flags         exception flags, only NV is ever raised
//   o_dest_reg      destination register of the FIFO head
//   o_busy          any op in the pipe or FIFO
// -----------------------------------------------------------------------------

package riscv_pkg;
  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_FEQ_S  = 5'd1,
    OP_FLT_S  = 5'd2,
    OP_FLE_S  = 5'd3,
    OP_FMIN_S = 5'd4,
    OP_FMAX_S = 5'd5,
    OP_FEQ_D  = 5'd6,
    OP_FLT_D  = 5'd7,
    OP_FLE_D  = 5'd8,
    OP_FMIN_D = 5'd9,
    OP_FMAX_D = 5'd10,
    OP_FADD_S = 5'd11,
    OP_FADD_D = 5'd12
  } instr_op_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;
endpackage

module fpu_compare_pipe #(
  parameter int FP_WIDTH_D = 64,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
`ifdef FPU_CMP_FLUSH_EN
  input  logic                   i_flush,
`endif
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_op_is_double,
  input  logic [FP_WIDTH_D-1:0]  i_operand_a,
  input  logic [FP_WIDTH_D-1:0]  i_operand_b,
  input  riscv_pkg::instr_op_e   i_operation,
  input  logic [4:0]             i_dest_reg,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [FP_WIDTH_D-1:0]  o_result,
  output logic                   o_is_compare,
  output riscv_pkg::fp_flags_t   o_flags,
  output logic [4:0]             o_dest_reg,
  output logic                   o_busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int USED_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  localparam logic [FP_WIDTH_D-1:0] CNAN_D = 64'h7FF8_0000_0000_0000;
  localparam logic [FP_WIDTH_D-1:0] CNAN_S = 64'hFFFF_FFFF_7FC0_0000;

  typedef struct packed {
    logic [FP_WIDTH_D-1:0] result;
    logic                  is_compare;
    riscv_pkg::fp_flags_t  flags;
    logic [4:0]            dest;
  } entry_t;

  // Operand view used by the comparator. mag holds the exponent+mantissa so
  // that sign-magnitude ordering reduces to an unsigned compare.
  typedef struct packed {
    logic [FP_WIDTH_D-1:0] val;
    logic                  sign;
    logic [62:0]           mag;
    logic                  nan;
    logic                  snan;
    logic                  zero;
  } unpk_t;

  // An S operand whose upper half is not all ones is an improperly boxed
  // value and is replaced by the (quiet) canonical NaN before anything else.
  function automatic unpk_t unpack(input logic [FP_WIDTH_D-1:0] x, input logic dbl);
    unpk_t u;
    if (dbl) begin
      u.val  = x;
      u.sign = x[63];
      u.mag  = x[62:0];
      u.nan  = (&x[62:52]) && (|x[51:0]);
      u.snan = u.nan && !x[51];
    end else begin
      u.val  = (&x[63:32]) ? x : CNAN_S;
      u.sign = u.val[31];
      u.mag  = {32'd0, u.val[30:0]};
      u.nan  = (&u.val[30:23]) && (|u.val[22:0]);
      u.snan = u.nan && !u.val[22];
    end
    u.zero = (u.mag == '0);
    return u;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic flush;
`ifdef FPU_CMP_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Compare / min / max datapath (evaluated on the accepted op)
  // ---------------------------------------------------------------------------
  unpk_t                 ua, ub;
  logic                  any_nan, any_snan, both_zero;
  logic                  lt_raw, eq_raw, lt_num, eq_num;
  logic [FP_WIDTH_D-1:0] canon_nan, min_val, max_val;
  entry_t                new_entry;

  always_comb begin
    ua        = unpack(i_operand_a, i_op_is_double);
    ub        = unpack(i_operand_b, i_op_is_double);
    any_nan   = ua.nan | ub.nan;
    any_snan  = ua.snan | ub.snan;
    both_zero = ua.zero & ub.zero;

    // Raw ordering treats -0 < +0, which is exactly what FMIN/FMAX need;
    // the compare instructions then fold the two zeros together.
    if (ua.sign != ub.sign) begin
      lt_raw = ua.sign;
    end else if (ua.sign) begin
      lt_raw = ua.mag > ub.mag;
    end else begin
      lt_raw = ua.mag < ub.mag;
    end
    eq_raw = (ua.sign == ub.sign) && (ua.mag == ub.mag);
    lt_num = lt_raw & ~both_zero;
    eq_num = eq_raw | both_zero;

    canon_nan = i_op_is_double ? CNAN_D : CNAN_S;
    if (ua.nan && ub.nan) begin
      min_val = canon_nan;
      max_val = canon_nan;
    end else if (ua.nan) begin
      min_val = ub.val;
      max_val = ub.val;
    end else if (ub.nan) begin
      min_val = ua.val;
      max_val = ua.val;
    end else begin
      min_val = lt_raw ? ua.val : ub.val;
      max_val = lt_raw ? ub.val : ua.val;
    end

    new_entry      = '0;
    new_entry.dest = i_dest_reg;
    case (i_operation)
      riscv_pkg::OP_FEQ_S, riscv_pkg::OP_FEQ_D: begin
        new_entry.result     = FP_WIDTH_D'(~any_nan & eq_num);
        new_entry.is_compare = 1'b1;
        new_entry.flags.nv   = any_snan;
      end
      riscv_pkg::OP_FLT_S, riscv_pkg::OP_FLT_D: begin
        new_entry.result     = FP_WIDTH_D'(~any_nan & lt_num);
        new_entry.is_compare = 1'b1;
        new_entry.flags.nv   = any_nan;
      end
      riscv_pkg::OP_FLE_S, riscv_pkg::OP_FLE_D: begin
        new_entry.result     = FP_WIDTH_D'(~any_nan & (lt_num | eq_num));
        new_entry.is_compare = 1'b1;
        new_entry.flags.nv   = any_nan;
      end
      riscv_pkg::OP_FMIN_S, riscv_pkg::OP_FMIN_D: begin
        new_entry.result   = min_val;
        new_entry.flags.nv = any_snan;
      end
      riscv_pkg::OP_FMAX_S, riscv_pkg::OP_FMAX_D: begin
        new_entry.result   = max_val;
        new_entry.flags.nv = any_snan;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Credit-based admission and delay pipe
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  entry_t             pipe_data_q [LATENCY];
  entry_t             pipe_data_d [LATENCY];
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic [USED_W-1:0]  credits_used;
  logic               accept;

  // Every op in the pipe already owns a FIFO slot, so the pipe can always
  // advance without checking downstream space.
  always_comb begin
    credits_used = USED_W'(fifo_count_q);
    for (int i = 0; i < LATENCY; i++) begin
      credits_used = credits_used + USED_W'(pipe_valid_q[i]);
    end
  end

  assign o_ready = ~i_rst & ~flush & (credits_used < USED_W'(FIFO_DEPTH));
  assign accept  = i_valid & o_ready;

  assign pipe_valid_d[0] = accept;
  assign pipe_data_d[0]  = new_entry;
  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
    assign pipe_data_d[gi]  = pipe_data_q[gi-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      pipe_valid_q <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
    end
    pipe_data_q <= pipe_data_d;
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  entry_t           fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_push, fifo_pop;
  entry_t           head;

  assign fifo_push = pipe_valid_q[LATENCY-1] & ~flush;
  assign fifo_pop  = (fifo_count_q != '0) & i_ready;

  always_comb begin
    wr_ptr_d     = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_count_d = fifo_count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
    end
  end

  assign head         = fifo_mem_q[rd_ptr_q];
  assign o_valid      = (fifo_count_q != '0);
  assign o_result     = o_valid ? head.result     : '0;
  assign o_is_compare = o_valid ? head.is_compare : 1'b0;
  assign o_flags      = o_valid ? head.flags      : '0;
  assign o_dest_reg   = o_valid ? head.dest       : '0;
  assign o_busy       = (|pipe_valid_q) | o_valid;

endmodule

// File: tb/tb_fpu_compare_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_compare_pipe
//   Directed test of fpu_compare_pipe with hand-computed expected values:
//   reset state, individual compare/min/max vectors with latency checks,
//   back-pressure fill and in-order drain, sustained push+pop streaming,
//   reset mid-operation and (with FPU_CMP_FLUSH_EN) flush.
// -----------------------------------------------------------------------------
module tb_fpu_compare_pipe;
  import riscv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
`ifdef FPU_CMP_FLUSH_EN
  logic        i_flush = 1'b0;
`endif
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_op_is_double = 1'b0;
  logic [63:0] i_operand_a = '0;
  logic [63:0] i_operand_b = '0;
  instr_op_e   i_operation = OP_NOP;
  logic [4:0]  i_dest_reg = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [63:0] o_result;
  logic        o_is_compare;
  fp_flags_t   o_flags;
  logic [4:0]  o_dest_reg;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  fpu_compare_pipe #(.FP_WIDTH_D(64), .LATENCY(2), .FIFO_DEPTH(4)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
`ifdef FPU_CMP_FLUSH_EN
    .i_flush        (i_flush),
`endif
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_op_is_double (i_op_is_double),
    .i_operand_a    (i_operand_a),
    .i_operand_b    (i_operand_b),
    .i_operation    (i_operation),
    .i_dest_reg     (i_dest_reg),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .o_is_compare   (o_is_compare),
    .o_flags        (o_flags),
    .o_dest_reg     (o_dest_reg),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive_flt(input logic [4:0] dest);
    i_valid        = 1'b1;
    i_operation    = OP_FLT_D;
    i_op_is_double = 1'b1;
    i_operand_a    = 64'h3FF0_0000_0000_0000;
    i_operand_b    = 64'h4000_0000_0000_0000;
    i_dest_reg     = dest;
  endtask

  // One op through an otherwise idle unit; result must appear exactly two
  // cycles after the accepting edge and be popped on the next edge.
  task automatic run_vec(input string name, input instr_op_e op, input logic dbl,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input logic cmp, input logic nv,
                         input logic [4:0] dest);
    @(negedge i_clk);
    i_valid        = 1'b1;
    i_operation    = op;
    i_op_is_double = dbl;
    i_operand_a    = a;
    i_operand_b    = b;
    i_dest_reg     = dest;
    i_ready        = 1'b1;
    check({name, "/ready"}, 64'(o_ready), 64'd1);
    step();
    i_valid = 1'b0;
    check({name, "/lat0"}, 64'(o_valid), 64'd0);
    step();
    check({name, "/lat1"}, 64'(o_valid), 64'd0);
    step();
    check({name, "/valid"}, 64'(o_valid), 64'd1);
    check({name, "/result"}, o_result, res);
    check({name, "/is_cmp"}, 64'(o_is_compare), 64'(cmp));
    check({name, "/flags"}, 64'(o_flags), 64'({nv, 4'b0000}));
    check({name, "/dest"}, 64'(o_dest_reg), 64'(dest));
    $display("%-10s a=%h b=%h -> res=%h cmp=%0d nv=%0d rd=%0d",
             name, a, b, o_result, o_is_compare, o_flags.nv, o_dest_reg);
    step();
    check({name, "/popped"}, 64'(o_valid), 64'd0);
    check({name, "/idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [4:0] exp_q[$];
    logic [4:0] exp_d;
    int         acc;
    int         nd;

    // ---------------- reset ----------------
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst/ready", 64'(o_ready), 64'd0);
    check("rst/valid", 64'(o_valid), 64'd0);
    check("rst/busy", 64'(o_busy), 64'd0);
    check("rst/result", o_result, 64'd0);
    check("rst/flags", 64'(o_flags), 64'd0);
    check("rst/dest", 64'(o_dest_reg), 64'd0);
    check("rst/is_cmp", 64'(o_is_compare), 64'd0);
    i_rst = 1'b0;
    step();
    check("rst/ready_after", 64'(o_ready), 64'd1);

    // ---------------- directed vectors ----------------
    run_vec("flt_d", OP_FLT_D, 1'b1, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
            64'd1, 1'b1, 1'b0, 5'd1);
    run_vec("fmin_s_sn", OP_FMIN_S, 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_4040_0000,
            64'hFFFF_FFFF_4040_0000, 1'b0, 1'b1, 5'd2);
    run_vec("feq_s_qn", OP_FEQ_S, 1'b0, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_7FC0_0000,
            64'd0, 1'b1, 1'b0, 5'd3);
    run_vec("fmax_d_z", OP_FMAX_D, 1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000,
            64'h0000_0000_0000_0000, 1'b0, 1'b0, 5'd4);
    run_vec("fmin_s_nb", OP_FMIN_S, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_3F80_0000,
            64'hFFFF_FFFF_3F80_0000, 1'b0, 1'b0, 5'd5);
    run_vec("fle_d_eq", OP_FLE_D, 1'b1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
            64'd1, 1'b1, 1'b0, 5'd6);
    run_vec("feq_d_z", OP_FEQ_D, 1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000,
            64'd1, 1'b1, 1'b0, 5'd7);
    run_vec("flt_s_qn", OP_FLT_S, 1'b0, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_3F80_0000,
            64'd0, 1'b1, 1'b1, 5'd8);
    run_vec("fmin_d_nn", OP_FMIN_D, 1'b1, 64'h7FF8_0000_0000_0001, 64'hFFF8_0000_0000_0000,
            64'h7FF8_0000_0000_0000, 1'b0, 1'b0, 5'd9);
    run_vec("fmax_s_neg", OP_FMAX_S, 1'b0, 64'hFFFF_FFFF_BF80_0000, 64'hFFFF_FFFF_C000_0000,
            64'hFFFF_FFFF_BF80_0000, 1'b0, 1'b0, 5'd10);
    run_vec("flt_d_neg", OP_FLT_D, 1'b1, 64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000,
            64'd1, 1'b1, 1'b0, 5'd11);
    run_vec("other_op", OP_FADD_D, 1'b1, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
            64'd0, 1'b0, 1'b0, 5'd12);
    run_vec("fmin_s_ss", OP_FMIN_S, 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_FF80_0002,
            64'hFFFF_FFFF_7FC0_0000, 1'b0, 1'b1, 5'd13);
    run_vec("feq_s_sn", OP_FEQ_S, 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_3F80_0000,
            64'd0, 1'b1, 1'b1, 5'd14);
    run_vec("fle_s_gt", OP_FLE_S, 1'b0, 64'hFFFF_FFFF_4040_0000, 64'hFFFF_FFFF_3F80_0000,
            64'd0, 1'b1, 1'b0, 5'd15);

    // ---------------- back-pressure fill and drain ----------------
    @(negedge i_clk);
    i_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      drive_flt(5'(10 + k));
      if (o_ready) begin
        acc++;
        exp_q.push_back(5'(10 + k));
      end
      step();
    end
    i_valid = 1'b0;
    $display("bp: issued 8 ops with i_ready low, accepted %0d", acc);
    check("bp/accepted", 64'(acc), 64'd4);
    check("bp/ready_low", 64'(o_ready), 64'd0);
    check("bp/busy", 64'(o_busy), 64'd1);
    i_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
      check("bp/valid", 64'(o_valid), 64'd1);
      check("bp/order", 64'(o_dest_reg), 64'(exp_d));
      check("bp/result", o_result, 64'd1);
      $display("bp: pop rd=%0d", o_dest_reg);
      step();
      if (j == 0) check("bp/ready_back", 64'(o_ready), 64'd1);
      if (j == 2) check("bp/busy_3pops", 64'(o_busy), 64'd1);
    end
    check("bp/empty", 64'(o_valid), 64'd0);
    check("bp/busy_low", 64'(o_busy), 64'd0);
    exp_q.delete();

    // ---------------- streaming push+pop ----------------
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_flt(5'(20 + k));
      exp_q.push_back(5'(20 + k));
      step();
    end
    i_valid = 1'b0;
    step();
    step();
    check("ss/prefill", 64'(o_valid), 64'd1);
    i_ready = 1'b1;
    nd = 23;
    for (int c = 0; c < 20; c++) begin
      drive_flt(5'(nd));
      check("ss/ready", 64'(o_ready), 64'd1);
      check("ss/valid", 64'(o_valid), 64'd1);
      if (o_ready) begin
        exp_q.push_back(5'(nd));
        nd++;
      end
      if (o_valid) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
        check("ss/order", 64'(o_dest_reg), 64'(exp_d));
        $display("ss: cycle %0d pop rd=%0d", c, o_dest_reg);
      end
      step();
    end
    i_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_valid) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
        check("ss/drain_order", 64'(o_dest_reg), 64'(exp_d));
        $display("ss: drain pop rd=%0d", o_dest_reg);
      end
      step();
    end
    check("ss/all_out", 64'(exp_q.size()), 64'd0);
    check("ss/idle", 64'(o_busy), 64'd0);
    exp_q.delete();

    // ---------------- reset mid-operation ----------------
    i_ready = 1'b0;
    drive_flt(5'd30);
    step();
    drive_flt(5'd31);
    step();
    i_valid = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    check("mrst/valid", 64'(o_valid), 64'd0);
    check("mrst/busy", 64'(o_busy), 64'd0);
    check("mrst/ready", 64'(o_ready), 64'd0);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("mrst/no_output", 64'(o_valid), 64'd0);
    end
    $display("mrst: reset with ops pending, nothing emitted afterwards");

`ifdef FPU_CMP_FLUSH_EN
    // ---------------- flush ----------------
    i_ready = 1'b0;
    drive_flt(5'd1);
    step();
    drive_flt(5'd2);
    step();
    i_valid = 1'b0;
    step();
    step();
    drive_flt(5'd3);
    step();
    drive_flt(5'd4);
    step();
    drive_flt(5'd5);
    i_flush = 1'b1;
    check("fl/ready_blocked", 64'(o_ready), 64'd0);
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl/valid", 64'(o_valid), 64'd0);
    check("fl/busy", 64'(o_busy), 64'd0);
    check("fl/ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("fl/no_output", 64'(o_valid), 64'd0);
    end
    $display("fl: flush with ops in pipe and FIFO, nothing emitted afterwards");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
